// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//
// Control unit of the lab processor. It sequences fetch, decode and execute.
// It also drives the program-counter Clear/Up inputs, the instruction-register
// load, the data-memory and register-file controls, and the ALU select.
//
// Ports:
//   Clock       in   system clock, all state changes on posedge
//   Reset       in   synchronous active-high reset (forces Init)
//   IR          in   current instruction, stable from the cycle after Fetch
//   PC_clr      out  program counter clear
//   PC_up       out  program counter increment
//   IR_ld       out  load IR from instruction ROM
//   D_addr      out  data-memory address (IR[11:4])
//   D_wr        out  data-memory write enable
//   RF_s        out  register-file write mux: 1 = data memory, 0 = ALU
//   RF_W_addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_addr  out  register-file read port A address
//   RF_Rb_addr  out  register-file read port B address
//   ALU_s0      out  ALU function: 0 = pass A, 1 = A+B, 2 = A-B
//   State       out  current state code (debug/display)
//
// There is no valid/ready handshake. IR is assumed valid from Decode onward,
// because the IR register loads at the end of Fetch.
// ---------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int IR_W = 16,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [IR_W-1:0] IR,
  output logic            PC_clr,
  output logic            PC_up,
  output logic            IR_ld,
  output logic [DA_W-1:0] D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_addr,
  output logic            RF_W_en,
  output logic [RA_W-1:0] RF_Ra_addr,
  output logic [RA_W-1:0] RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  state_t state;

  logic [3:0]      opcode;
  logic [DA_W-1:0] ir_daddr;
  logic [RA_W-1:0] ir_ra;
  logic [RA_W-1:0] ir_rb;
  logic [RA_W-1:0] ir_rc;

  assign opcode   = IR[15:12];
  assign ir_daddr = IR[11:4];
  assign ir_ra    = IR[11:8];
  assign ir_rb    = IR[7:4];
  assign ir_rc    = IR[3:0];

  assign State = state;

  // State register. Reset takes priority over every transition, Halt included.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_NOOP:  state <= S_NOOP;
            OP_STORE: state <= S_STORE;
            OP_LOAD:  state <= S_LOADA;
            OP_ADD:   state <= S_ADD;
            OP_SUB:   state <= S_SUB;
            OP_HALT:  state <= S_HALT;
            default:  state <= S_NOOP;  // undefined opcodes behave as NOOP
          endcase
        end
        S_NOOP:   state <= S_FETCH;
        S_LOADA:  state <= S_LOADB;
        S_LOADB:  state <= S_FETCH;
        S_STORE:  state <= S_FETCH;
        S_ADD:    state <= S_FETCH;
        S_SUB:    state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;      // encodings 10..15 recover via Init
      endcase
    end
  end

  // Moore outputs. They depend on the state register and the live IR fields,
  // so a new IR is reflected in the same cycle. No extra register stage.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // LoadA only presents the address. The RAM is synchronous, so the
      // register-file write waits one cycle until LoadB.
      S_LOADA: begin
        D_addr    = ir_daddr;
        RF_s      = 1'b1;
        RF_W_addr = ir_rc;
      end
      S_LOADB: begin
        D_addr    = ir_daddr;
        RF_s      = 1'b1;
        RF_W_addr = ir_rc;
        RF_W_en   = 1'b1;
      end
      // Store routes register Ra through the ALU in pass-A mode to the RAM.
      S_STORE: begin
        D_addr     = ir_daddr;
        RF_Ra_addr = ir_rc;
        ALU_s0     = ALU_PASS;
        D_wr       = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = ir_ra;
        RF_Rb_addr = ir_rb;
        RF_W_addr  = ir_rc;
        ALU_s0     = ALU_ADD;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_addr = ir_ra;
        RF_Rb_addr = ir_rb;
        RF_W_addr  = ir_rc;
        ALU_s0     = ALU_SUB;
        RF_W_en    = 1'b1;
      end
      default: ;  // Decode, Noop, Halt: all controls low
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  // ---------------- clock / reset ----------------
  logic        Clock;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;

  int checks = 0;
  int errors = 0;
  int seq_q[$];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  cpu_control_fsm dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State)
  );

  // ---------------- reference model ----------------
  // Output vector order: PC_clr PC_up IR_ld D_addr D_wr RF_s RF_W_addr RF_W_en Ra Rb ALU
  function automatic logic [28:0] exp_out(input int st, input logic [15:0] ir);
    logic       clr, up, ld, dwr, rfs, wen;
    logic [7:0] da;
    logic [3:0] wa, ra, rb;
    logic [2:0] alu;
    clr = 0; up = 0; ld = 0; dwr = 0; rfs = 0; wen = 0;
    da = 0; wa = 0; ra = 0; rb = 0; alu = 0;
    case (st)
      0: clr = 1;
      1: begin ld = 1; up = 1; end
      4: begin da = ir[11:4]; rfs = 1; wa = ir[3:0]; end
      5: begin da = ir[11:4]; rfs = 1; wa = ir[3:0]; wen = 1; end
      6: begin da = ir[11:4]; ra = ir[3:0]; dwr = 1; end
      7: begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; alu = 1; wen = 1; end
      8: begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; alu = 2; wen = 1; end
      default: ;
    endcase
    return {clr, up, ld, da, dwr, rfs, wa, wen, ra, rb, alu};
  endfunction

  // States visited after Fetch for one instruction (Decode onward).
  function automatic void build_seq(input logic [15:0] ir, input int halt_cycles);
    seq_q = {};
    seq_q.push_back(2);
    case (ir[15:12])
      4'd0: seq_q.push_back(3);
      4'd1: seq_q.push_back(6);
      4'd2: begin seq_q.push_back(4); seq_q.push_back(5); end
      4'd3: seq_q.push_back(7);
      4'd4: seq_q.push_back(8);
      4'd5: for (int i = 0; i < halt_cycles; i++) seq_q.push_back(9);
      default: seq_q.push_back(3);
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check_now(input int es, input string tag);
    logic [3:0]  es_v;
    logic [28:0] eo, ao;
    es_v = es[3:0];
    eo = exp_out(es, IR);
    ao = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
          RF_Ra_addr, RF_Rb_addr, ALU_s0};
    checks++;
    assert (State === es_v) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, State, es_v);
    end
    checks++;
    assert (ao === eo) else begin
      errors++;
      $error("FAIL %s outputs: observed %h expected %h (state %0d ir %h)", tag, ao, eo, es, IR);
    end
    checks++;
    assert (!(PC_clr && PC_up)) else begin
      errors++;
      $error("FAIL %s pc_excl: observed clr=%b up=%b expected not both", tag, PC_clr, PC_up);
    end
  endtask

  // ---------------- driver ----------------
  // Called while the DUT is in Fetch. Presents ir, walks the expected states,
  // then checks the return to Fetch (except after HALT).
  task automatic run_instr(input logic [15:0] ir, input string tag);
    IR = ir;
    build_seq(ir, 20);
    foreach (seq_q[i]) begin
      @(negedge Clock);
      check_now(seq_q[i], tag);
    end
    if (ir[15:12] != 4'd5) begin
      @(negedge Clock);
      check_now(1, {tag, "_refetch"});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rir;
    logic [3:0]  op;
    Reset = 1'b1;
    IR    = 16'h0000;
    @(negedge Clock);
    @(negedge Clock);
    check_now(0, "reset_hold");
    Reset = 1'b0;
    @(negedge Clock);
    check_now(1, "first_fetch");

    run_instr(16'h3214, "add");
    run_instr(16'h2A53, "load");
    run_instr(16'h1C7B, "store");
    run_instr(16'h4560, "sub");
    run_instr(16'hF123, "undef");
    run_instr(16'h0ABC, "noop");

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5) op = 4'd2;
      rir = {op, 12'($urandom)};
      run_instr(rir, "rand");
    end

    // Reset in the middle of a LOAD: no register-file write may occur.
    IR = 16'h2A53;
    @(negedge Clock);
    check_now(2, "rst_load_decode");
    @(negedge Clock);
    check_now(4, "rst_load_loada");
    Reset = 1'b1;
    @(negedge Clock);
    check_now(0, "rst_load_init");
    Reset = 1'b0;
    @(negedge Clock);
    check_now(1, "rst_load_fetch");

    // HALT: held for 20 cycles, only Reset leaves it.
    run_instr(16'h5000, "halt");
    Reset = 1'b1;
    @(negedge Clock);
    check_now(0, "halt_reset_init");
    Reset = 1'b0;
    @(negedge Clock);
    check_now(1, "halt_reset_fetch");
    run_instr(16'h3214, "add_after_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
